// File: rtl/act_lut_pkg.sv
// Shared definitions for the activation-function LUT fetch stage and its
// breakpoint table: default widths, entry type and the reset/ROM contents.
package act_lut_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_FRAC_W = 4;
    localparam int unsigned N_ENT      = (1 << (DEF_DATA_W - DEF_FRAC_W)) + 1;
    localparam int unsigned ADDR_W     = $clog2(N_ENT);

    typedef logic signed [DEF_DATA_W-1:0] lut_entry_t;
    typedef lut_entry_t lut_table_t [N_ENT];

    // Evenly spaced ramp: entry i holds 4*i-32, i.e. -32..32.
    function automatic lut_table_t lut_default();
        lut_table_t t;
        for (int unsigned i = 0; i < N_ENT; i++) begin
            t[i] = lut_entry_t'(4 * int'(i) - 32);
        end
        return t;
    endfunction

    localparam lut_table_t LUT_INIT = lut_default();

endpackage

// File: rtl/act_lut_fetch_if.sv
// Input (x) and output (base/next_data/change/remaining) streams of the
// LUT fetch stage. slave = the fetch stage, master = its environment.
interface act_lut_fetch_if
    import act_lut_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] x;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] next_data;
    logic [DATA_W-1:0] change;
    logic [DATA_W-1:0] remaining;

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, base, next_data, change, remaining
    );

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, base, next_data, change, remaining
    );

endinterface

// File: rtl/act_lut_table.sv
// Breakpoint table with two combinational read ports (addr, addr+1).
// With ACT_LUT_WRITE_EN defined the table is writable flops reset to
// LUT_INIT; otherwise it is the constant LUT_INIT and has no clock.
module act_lut_table
    import act_lut_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TBL_ENT = N_ENT,
    parameter int unsigned TBL_AW  = $clog2(TBL_ENT)
) (
`ifdef ACT_LUT_WRITE_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [TBL_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
`endif
    input  logic [TBL_AW-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1
);

    logic [TBL_AW-1:0] w_raddr1;

    assign w_raddr1 = i_raddr + TBL_AW'(1);

`ifdef ACT_LUT_WRITE_EN
    logic [DATA_W-1:0] r_mem [TBL_ENT];

    // Reload defaults on reset; out-of-range write addresses are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TBL_ENT; i++) begin
                r_mem[i] <= DATA_W'(LUT_INIT[i]);
            end
        end else if (i_we && (i_waddr < TBL_AW'(TBL_ENT))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write returns old data.
    always_comb begin
        o_rdata0 = r_mem[i_raddr];
        o_rdata1 = r_mem[w_raddr1];
    end
`else
    // Constant ROM lookup.
    always_comb begin
        o_rdata0 = DATA_W'(LUT_INIT[i_raddr]);
        o_rdata1 = DATA_W'(LUT_INIT[w_raddr1]);
    end
`endif

endmodule

// File: rtl/act_lut_fetch.sv
// Activation LUT fetch stage: splits signed fixed-point x into a table index
// and fractional remainder, fetches the bracketing breakpoints and presents
// them to the interpolator through a 2-stage valid/ready pipeline.
// Optional feature macro: ACT_LUT_WRITE_EN (adds tbl_* write port).
module act_lut_fetch
    import act_lut_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    act_lut_fetch_if.slave       bus
`ifdef ACT_LUT_WRITE_EN
    ,
    input  logic                 tbl_we,
    input  logic [4:0]           tbl_addr,
    input  logic [DATA_W-1:0]    tbl_data
`endif
);

    localparam int unsigned IDX_W   = DATA_W - FRAC_W;
    localparam int unsigned TBL_ENT = (1 << IDX_W) + 1;
    localparam int unsigned TBL_AW  = $clog2(TBL_ENT);

    logic              r_s1_v;
    logic [IDX_W-1:0]  r_s1_idx;
    logic [FRAC_W-1:0] r_s1_frac;
    logic              r_s2_v;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_next;
    logic [DATA_W-1:0] r_change;
    logic [DATA_W-1:0] r_rem;

    logic              w_s2_load;
    logic              w_s1_load;
    logic [IDX_W-1:0]  w_idx;
    logic [TBL_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;

    // Handshake enables and index split. Adding half the range to the signed
    // integer part is the same as inverting its sign bit.
    always_comb begin
        w_s2_load = !r_s2_v || bus.out_ready;
        w_s1_load = !r_s1_v || w_s2_load;
        w_idx     = {~bus.x[DATA_W-1], bus.x[DATA_W-2:FRAC_W]};
        w_addr    = TBL_AW'(r_s1_idx);
    end

    act_lut_table #(
        .DATA_W  (DATA_W),
        .TBL_ENT (TBL_ENT),
        .TBL_AW  (TBL_AW)
    ) u_table (
`ifdef ACT_LUT_WRITE_EN
        .clk      (clk),
        .rst      (rst),
        .i_we     (tbl_we),
        .i_waddr  (tbl_addr),
        .i_wdata  (tbl_data),
`endif
        .i_raddr  (w_addr),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    // Stage 1: capture table index and fractional bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v    <= 1'b0;
            r_s1_idx  <= '0;
            r_s1_frac <= '0;
        end else if (w_s1_load) begin
            r_s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_idx  <= w_idx;
                r_s1_frac <= bus.x[FRAC_W-1:0];
            end
        end
    end

    // Stage 2: register breakpoints, slope and remainder; held while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_v   <= 1'b0;
            r_base   <= '0;
            r_next   <= '0;
            r_change <= '0;
            r_rem    <= '0;
        end else if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_base   <= w_rd0;
                r_next   <= w_rd1;
                r_change <= w_rd1 - w_rd0;
                r_rem    <= DATA_W'(r_s1_frac);
            end
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_v;
    assign bus.base      = r_base;
    assign bus.next_data = r_next;
    assign bus.change    = r_change;
    assign bus.remaining = r_rem;

endmodule

// File: tb/tb_act_lut_fetch.sv
// Directed bench for act_lut_fetch: reset state, single lookups, stalled
// stream, mid-stream reset and (with ACT_LUT_WRITE_EN) table writes.
module tb_act_lut_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;

    act_lut_fetch_if #(.DATA_W(8)) u_if ();

`ifdef ACT_LUT_WRITE_EN
    logic       tbl_we   = 1'b0;
    logic [4:0] tbl_addr = '0;
    logic [7:0] tbl_data = '0;
`endif

    act_lut_fetch #(.DATA_W(8), .FRAC_W(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (u_if)
`ifdef ACT_LUT_WRITE_EN
        ,
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    // One item through an idle pipe, checked two edges after presentation.
    task automatic send_one(input string tag, input logic [7:0] xv,
                            input int eb, input int en, input int ec, input int er);
        u_if.x         = xv;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, ".valid"},  32'(u_if.out_valid), 32'd1);
        check({tag, ".base"},   sx(u_if.base),       eb);
        check({tag, ".next"},   sx(u_if.next_data),  en);
        check({tag, ".change"}, sx(u_if.change),     ec);
        check({tag, ".rem"},    32'(u_if.remaining), er);
        @(posedge clk); #1;
    endtask

    logic [7:0] xs       [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
    logic [7:0] exp_base [4] = '{8'd0, 8'd4, 8'd8, 8'd12};
    int         got_cnt = 0;

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.x         = '0;
        u_if.out_ready = 1'b0;

        #12;
        check("rst.out_valid", 32'(u_if.out_valid), 32'd0);
        check("rst.base",      32'(u_if.base),      32'd0);
        check("rst.next",      32'(u_if.next_data), 32'd0);
        check("rst.change",    32'(u_if.change),    32'd0);
        check("rst.rem",       32'(u_if.remaining), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel.in_ready", 32'(u_if.in_ready), 32'd1);

        send_one("x00", 8'h00,   0,   4, 4,  0);
        send_one("x7F", 8'h7F,  28,  32, 4, 15);
        send_one("x80", 8'h80, -32, -28, 4,  0);
        send_one("xC5", 8'hC5, -16, -12, 4,  5);

        // Four back-to-back items with a 3-cycle output stall after the first.
        fork
            begin : drv
                for (int i = 0; i < 4; i++) begin
                    int guard;
                    guard = 0;
                    u_if.in_valid = 1'b1;
                    u_if.x        = xs[i];
                    @(negedge clk);
                    while (!u_if.in_ready && guard < 20) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 20) check("stall.accept_timeout", 32'd0, 32'd1);
                    @(posedge clk); #1;
                end
                u_if.in_valid = 1'b0;
            end
            begin : rdy
                u_if.out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 u_if.out_ready = 1'b0;
                @(negedge clk);
                check("stall.in_ready",  32'(u_if.in_ready),  32'd0);
                check("stall.out_valid", 32'(u_if.out_valid), 32'd1);
                repeat (3) @(posedge clk);
                #1 u_if.out_ready = 1'b1;
            end
            begin : mon
                logic [7:0] held;
                logic       held_v;
                int         cyc;
                held   = '0;
                held_v = 1'b0;
                cyc    = 0;
                while (got_cnt < 4 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (u_if.out_valid && u_if.out_ready) begin
                        check($sformatf("stall.item%0d", got_cnt), sx(u_if.base), sx(exp_base[got_cnt]));
                        got_cnt++;
                        held_v = 1'b0;
                    end else if (u_if.out_valid) begin
                        if (held_v) check("stall.hold", 32'(u_if.base), 32'(held));
                        held   = u_if.base;
                        held_v = 1'b1;
                    end
                end
                check("stall.count", got_cnt, 32'd4);
            end
        join

        // Reset with two items in flight.
        @(posedge clk); #1;
        u_if.out_ready = 1'b1;
        u_if.in_valid  = 1'b1;
        u_if.x         = 8'h20;
        @(posedge clk); #1;
        u_if.x = 8'h30;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        check("inflight.out_valid", 32'(u_if.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst.out_valid", 32'(u_if.out_valid), 32'd0);
        check("arst.base",      32'(u_if.base),      32'd0);
        check("arst.rem",       32'(u_if.remaining), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (u_if.out_valid) seen++;
            end
            check("arst.no_stale", seen, 32'd0);
        end

`ifdef ACT_LUT_WRITE_EN
        // Write to entry 9 while an item addressing it sits in S1.
        @(posedge clk); #1;
        u_if.x         = 8'h10;
        u_if.in_valid  = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        tbl_we   = 1'b1;
        tbl_addr = 5'd9;
        tbl_data = 8'd100;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        check("wr_same.base",   sx(u_if.base),   32'd4);
        check("wr_same.change", sx(u_if.change), 32'd4);
        @(posedge clk); #1;

        send_one("wr9", 8'h10, 100, 8, -92, 0);

        tbl_we   = 1'b1;
        tbl_addr = 5'd20;
        tbl_data = 8'd55;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        send_one("wr20_e4", 8'hC5, -16, -12, 4, 5);
        send_one("wr20_e9", 8'h10, 100,   8, -92, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
